// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampled start/data/stop decoding into a
// first-word-fall-through byte buffer with level, framing and overflow reporting.
module uart_receiver #(
  parameter int CLK_FREQ     = 1_843_200,
  parameter int BUFFER_DEPTH = 32
) (
  input  logic       clock,
  input  logic       reset_n_i,
  input  logic       uart_rx_i,
  input  logic [1:0] baudrate_select_i,
  input  logic       data_read_i,
  input  logic [5:0] data_buffer_avail_tresh_i,
  output logic [7:0] data_o,
  output logic       data_buffer_empty_o,
  output logic       data_buffer_full_o,
  output logic       data_buffer_avail_o,
  output logic       frame_error_o,
  output logic       overflow_o
);
  localparam int AW   = $clog2(BUFFER_DEPTH);
  localparam int CW   = AW + 1;
  localparam int DIV0 = CLK_FREQ / (9600 * 16);
  localparam int DIV1 = CLK_FREQ / (19200 * 16);
  localparam int DIV2 = CLK_FREQ / (57600 * 16);
  localparam int DIV3 = CLK_FREQ / (115200 * 16);
  localparam int DW   = (DIV0 > 1) ? $clog2(DIV0) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic          r_rx_d;
  logic [1:0]    r_baud;
  logic [DW-1:0] r_div_cnt;
  logic [DW-1:0] w_div_m1;
  logic [3:0]    r_tc;
  logic [2:0]    r_bc;
  logic [7:0]    r_shift;
  logic          r_frame_err;
  logic          w_rx_s;
  logic          w_tick;
  logic          w_stop_smp;

  assign w_rx_s     = r_sync[1];
  assign w_tick     = (r_div_cnt == w_div_m1);
  assign w_stop_smp = (r_state == S_STOP) && w_tick && (r_tc == 4'd15);

  always_comb begin
    w_div_m1 = DW'(DIV0 - 1);
    case (r_baud)
      2'd1:    w_div_m1 = DW'(DIV1 - 1);
      2'd2:    w_div_m1 = DW'(DIV2 - 1);
      2'd3:    w_div_m1 = DW'(DIV3 - 1);
      default: w_div_m1 = DW'(DIV0 - 1);
    endcase
  end

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync      <= 2'b11;
      r_rx_d      <= 1'b1;
      r_state     <= S_IDLE;
      r_baud      <= 2'd0;
      r_div_cnt   <= '0;
      r_tc        <= 4'd0;
      r_bc        <= 3'd0;
      r_shift     <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], uart_rx_i};
      r_rx_d      <= w_rx_s;
      r_frame_err <= w_stop_smp && !w_rx_s;
      r_div_cnt   <= w_tick ? '0 : r_div_cnt + DW'(1);
      case (r_state)
        S_IDLE: if (r_rx_d && !w_rx_s) begin
          // baud is frozen here so a mid-frame select change only hits the next frame
          r_state   <= S_START;
          r_div_cnt <= '0;
          r_tc      <= 4'd0;
          r_bc      <= 3'd0;
          r_baud    <= baudrate_select_i;
        end
        S_START: if (w_tick) begin
          if (r_tc == 4'd7) begin
            if (w_rx_s) r_state <= S_IDLE;
            else begin
              r_tc    <= 4'd0;
              r_state <= S_DATA;
            end
          end else r_tc <= r_tc + 4'd1;
        end
        S_DATA: if (w_tick) begin
          if (r_tc == 4'd15) begin
            r_shift[r_bc] <= w_rx_s;
            r_tc          <= 4'd0;
            r_bc          <= r_bc + 3'd1;
            if (r_bc == 3'd7) r_state <= S_STOP;
          end else r_tc <= r_tc + 4'd1;
        end
        S_STOP: if (w_tick) begin
          if (r_tc == 4'd15) r_state <= S_IDLE;
          else r_tc <= r_tc + 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]    r_mem [BUFFER_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [6:0]    w_thr, w_cnt7;
  logic          w_push, w_pop, w_push_ok, w_avail_nxt;
  logic          r_empty, r_full, r_avail, r_overflow;
  logic [7:0]    r_data;

  assign w_push    = w_stop_smp && w_rx_s;
  assign w_pop     = data_read_i && !r_empty;
  // a pop on the same edge frees the slot, so a full buffer can still accept
  assign w_push_ok = w_push && (!r_full || w_pop);
  assign w_rd_nxt  = r_rd_ptr + AW'(w_pop);
  assign w_cnt7    = 7'(w_count_nxt);
  assign w_thr     = (data_buffer_avail_tresh_i == 6'd0) ? 7'd1 : {1'b0, data_buffer_avail_tresh_i};
  assign w_avail_nxt = (w_cnt7 >= w_thr) ||
                       ((w_thr > 7'(BUFFER_DEPTH)) && (w_count_nxt == CW'(BUFFER_DEPTH)));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push_ok && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clock or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_avail    <= 1'b0;
      r_overflow <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr   <= w_rd_nxt;
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == CW'(BUFFER_DEPTH));
      r_avail    <= w_avail_nxt;
      r_overflow <= w_push && r_full && !w_pop;
      // head is the incoming byte when it lands in the slot being exposed
      if (w_count_nxt != '0)
        r_data <= (w_push_ok && (w_rd_nxt == r_wr_ptr)) ? r_shift : r_mem[w_rd_nxt];
    end
  end

  assign data_o              = r_data;
  assign data_buffer_empty_o = r_empty;
  assign data_buffer_full_o  = r_full;
  assign data_buffer_avail_o = r_avail;
  assign frame_error_o       = r_frame_err;
  assign overflow_o          = r_overflow;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: serial frames are driven bit by bit and
// expected bytes are queued, then compared as the buffer is drained.
module tb_uart_receiver;
  localparam int DEPTH = 32;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [1:0] baud;
  logic       rd;
  logic [5:0] thr;
  logic [7:0] data_o;
  logic       empty, full, avail, fe, ov;

  int n_pass = 0, n_chk = 0;
  int fe_cnt = 0, fe_long = 0, ov_cnt = 0, exp_ovf = 0;
  logic fe_prev = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  uart_receiver #(.CLK_FREQ(1_843_200), .BUFFER_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n_i(reset_n), .uart_rx_i(rx),
    .baudrate_select_i(baud), .data_read_i(rd), .data_buffer_avail_tresh_i(thr),
    .data_o(data_o), .data_buffer_empty_o(empty), .data_buffer_full_o(full),
    .data_buffer_avail_o(avail), .frame_error_o(fe), .overflow_o(ov));

  always @(negedge clock) begin
    if (fe) begin
      fe_cnt <= fe_cnt + 1;
      if (fe_prev) fe_long <= fe_long + 1;
    end
    if (ov) ov_cnt <= ov_cnt + 1;
    fe_prev <= fe;
  end

  // drives start + data + stop level, returns at mid stop bit
  task automatic send_frame(input logic [7:0] b, input int div, input logic stop);
    @(posedge clock); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16*div) @(posedge clock);
      #1 rx = b[i];
    end
    repeat (16*div) @(posedge clock);
    #1 rx = stop;
    repeat (8*div) @(posedge clock);
  endtask

  task automatic end_frame(input int div);
    repeat (8*div) @(posedge clock);
    #1 rx = 1'b1;
    repeat (16*div + 4) @(posedge clock);
  endtask

  task automatic send_good(input logic [7:0] b, input int div);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf++;
    send_frame(b, div, 1'b1);
    end_frame(div);
  endtask

  task automatic do_read(input string nm);
    logic [7:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, data_o=%h empty=%b", nm, data_o, empty);
      return;
    end
    e = exp_q.pop_front();
    @(negedge clock);
    if (data_o !== e || empty !== 1'b0)
      $display("FAIL %s: data_o=%h empty=%b, expected data_o=%h empty=0", nm, data_o, empty, e);
    else n_pass++;
    @(posedge clock); #1 rd = 1'b1;
    @(posedge clock); #1 rd = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    n_chk++;
    if ({empty, full, avail, data_o} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_flags: empty=%b full=%b avail=%b data=%h, expected 1 0 0 00", empty, full, avail, data_o);
    else n_pass++;
    n_chk++;
    if (fe_cnt !== 0 || ov_cnt !== 0)
      $display("FAIL reset_pulses: fe=%0d ov=%0d, expected 0 0", fe_cnt, ov_cnt);
    else n_pass++;
  endtask

  task automatic test_basic;
    int k;
    baud = 2'b00;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 12, 1'b1);
    for (k = 0; k < 6 && empty; k++) @(negedge clock);
    n_chk++;
    if (empty !== 1'b0) $display("FAIL basic_write_latency: empty=%b after %0d cycles, expected 0", empty, k);
    else n_pass++;
    end_frame(12);
    do_read("basic_data");
    @(negedge clock);
    n_chk++;
    if (empty !== 1'b1) $display("FAIL basic_empty_after_read: empty=%b, expected 1", empty);
    else n_pass++;
  endtask

  task automatic test_frame_error;
    int fe0 = fe_cnt;
    baud = 2'b11;
    send_frame(8'h3C, 1, 1'b0);
    end_frame(1);
    n_chk++;
    if (fe_cnt - fe0 !== 1 || fe_long !== 0)
      $display("FAIL frame_error_pulse: pulses=%0d long=%0d, expected 1 0", fe_cnt - fe0, fe_long);
    else n_pass++;
    n_chk++;
    if (empty !== 1'b1) $display("FAIL frame_error_empty: empty=%b, expected 1", empty);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int fe0 = fe_cnt;
    baud = 2'b00;
    @(posedge clock); #1 rx = 1'b0;
    repeat (5*12) @(posedge clock);
    #1 rx = 1'b1;
    repeat (300) @(posedge clock);
    n_chk++;
    if (empty !== 1'b1 || fe_cnt !== fe0)
      $display("FAIL glitch_reject: empty=%b fe_pulses=%0d, expected 1 0", empty, fe_cnt - fe0);
    else n_pass++;
    baud = 2'b11;
    send_good(8'h5A, 1);
    do_read("glitch_next_frame");
  endtask

  task automatic test_fill_overflow;
    baud = 2'b11;
    thr  = 6'd4;
    for (int i = 1; i <= 4; i++) begin
      send_good(8'(i), 1);
      @(negedge clock);
      n_chk++;
      if (avail !== (i >= 4)) $display("FAIL avail_at_%0d: avail=%b, expected %b", i, avail, i >= 4);
      else n_pass++;
    end
    for (int i = 5; i <= DEPTH; i++) send_good(8'(i), 1);
    @(negedge clock);
    n_chk++;
    if (full !== 1'b1 || empty !== 1'b0) $display("FAIL fill_full: full=%b empty=%b, expected 1 0", full, empty);
    else n_pass++;
    thr = 6'd40;
    repeat (2) @(negedge clock);
    n_chk++;
    if (avail !== 1'b1) $display("FAIL thresh_over_depth: avail=%b, expected 1", avail);
    else n_pass++;
    thr = 6'd4;
    send_good(8'hFF, 1);
    @(negedge clock);
    n_chk++;
    if (ov_cnt !== exp_ovf) $display("FAIL overflow_pulse: count=%0d, expected %0d", ov_cnt, exp_ovf);
    else n_pass++;
    n_chk++;
    if (data_o !== exp_q[0] || full !== 1'b1)
      $display("FAIL overflow_head: data_o=%h full=%b, expected %h 1", data_o, full, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_full_pop_push;
    baud = 2'b11;
    fork
      begin
        send_frame(8'h21, 1, 1'b1);
        end_frame(1);
      end
      begin
        logic [7:0] e;
        // pop lands on the same edge as the stop-sample write commit
        repeat (155) @(posedge clock);
        #1;
        e = exp_q.pop_front();
        exp_q.push_back(8'h21);
        n_chk++;
        if (data_o !== e) $display("FAIL pop_push_head: data_o=%h, expected %h", data_o, e);
        else n_pass++;
        rd = 1'b1;
        @(posedge clock); #1 rd = 1'b0;
        n_chk++;
        if (full !== 1'b1 || data_o !== exp_q[0])
          $display("FAIL pop_push_full: full=%b data_o=%h, expected 1 %h", full, data_o, exp_q[0]);
        else n_pass++;
      end
    join
    n_chk++;
    if (ov_cnt !== exp_ovf) $display("FAIL pop_push_no_overflow: count=%0d, expected %0d", ov_cnt, exp_ovf);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) do_read("drain");
    @(negedge clock);
    n_chk++;
    if (empty !== 1'b1 || full !== 1'b0) $display("FAIL drain_empty: empty=%b full=%b, expected 1 0", empty, full);
    else n_pass++;
  endtask

  task automatic test_baud_switch;
    int fe0 = fe_cnt;
    baud = 2'b11;
    fork
      send_good(8'h96, 1);
      begin
        repeat (40) @(posedge clock);
        #1 baud = 2'b00;
      end
    join
    do_read("baud_switch_data");
    n_chk++;
    if (fe_cnt !== fe0) $display("FAIL baud_switch_fe: pulses=%0d, expected 0", fe_cnt - fe0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    baud = 2'b11;
    thr  = 6'd0;
    send_good(8'h77, 1);
    @(negedge clock);
    n_chk++;
    if (avail !== 1'b1 || data_o !== exp_q[0])
      $display("FAIL thresh_zero: avail=%b data_o=%h, expected 1 %h", avail, data_o, exp_q[0]);
    else n_pass++;
    @(posedge clock); #1 rx = 1'b0;
    repeat (60) @(posedge clock);
    #1 reset_n = 1'b0;
    #2;
    n_chk++;
    if ({empty, full, avail, data_o, fe, ov} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL midframe_reset: empty=%b full=%b avail=%b data=%h fe=%b ov=%b, expected 1 0 0 00 0 0",
               empty, full, avail, data_o, fe, ov);
    else n_pass++;
    rx = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (300) @(posedge clock);
    @(negedge clock);
    n_chk++;
    if (empty !== 1'b1 || data_o !== 8'h00)
      $display("FAIL midframe_no_partial: empty=%b data_o=%h, expected 1 00", empty, data_o);
    else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    baud    = 2'b00;
    rd      = 1'b0;
    thr     = 6'd4;
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    test_reset;
    test_basic;
    test_frame_error;
    test_glitch;
    test_fill_overflow;
    test_full_pop_push;
    test_baud_switch;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver, the counterpart of the existing UART transmitter.
- Frame format: 8N1, LSB first, line idle high.
- Samples uart_rx_i at 16x the selected baud rate.
- Correctly framed bytes go into a first-word-fall-through buffer that the system side drains.
- Reports buffer level against a programmable threshold, and reports framing and overflow errors.

Parameters:
- CLK_FREQ, 1_843_200, system clock frequency in Hz. The 16x divisor is CLK_FREQ/(baud*16) and must be an integer for every baud rate.
- BUFFER_DEPTH, 32, receive buffer depth in bytes. Must be a power of 2, at most 63.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- uart_rx_i  input  1  serial line, asynchronous to clock.
- baudrate_select_i  input  2  00=9600, 01=19200, 10=57600, 11=115200.
- data_read_i  input  1  pops the head byte when the buffer is not empty.
- data_buffer_avail_tresh_i  input  6  level at or above which data_buffer_avail_o asserts. A value of 0 is treated as 1.
- data_o  output  8  head byte of the buffer; valid while data_buffer_empty_o=0.
- data_buffer_empty_o  output  1  buffer holds 0 bytes.
- data_buffer_full_o  output  1  buffer holds BUFFER_DEPTH bytes.
- data_buffer_avail_o  output  1  count >= effective threshold.
- frame_error_o  output  1  one-cycle pulse: stop bit sampled low.
- overflow_o  output  1  one-cycle pulse: valid byte dropped because the buffer was full.

Behaviour:
Reset:
- Clock reset is async assert, synchronous release via normal flops.
- Reset values: data_o=0, data_buffer_empty_o=1, data_buffer_full_o=0, data_buffer_avail_o=0, frame_error_o=0, overflow_o=0.
- The 2-flop synchronizer resets to 1, the FSM to IDLE, and the buffer pointers and count to 0.
- A reset in mid-frame abandons the frame; no partial byte is stored.

Input path:
- uart_rx_i passes through a 2-flop synchronizer; rx_s is the synchronized value.
- The tick generator pulses once every DIV = CLK_FREQ/(baud*16) clocks.
- Baud rate is latched at start detection. Changing baudrate_select_i mid-frame affects only the next frame.

FSM, with tick counter tc (0..15) and bit counter bc (0..7):
- IDLE: a falling edge on rx_s clears the tick divider and tc, then goes to START.
- START: at tc=7 (mid start bit), if rx_s=1 it is a glitch and the FSM returns to IDLE. Otherwise tc is cleared and the FSM goes to DATA.
- DATA: every 16 ticks, rx_s is shifted into shift[bc], bc increments. After bc=7 the FSM goes to STOP.
- STOP: 16 ticks after the last data sample (mid stop bit), rx_s is sampled.
  - rx_s=1: write shift into the buffer. If the buffer is full, do not write and pulse overflow_o instead.
  - rx_s=0: discard the byte and pulse frame_error_o.
  - In both cases go to IDLE. A new start edge is accepted from the next cycle.
- Error pulses are registered: high for exactly one clock, starting the cycle after the stop sample.

Buffer (first-word fall-through):
- A write is committed on the clock edge after the stop-sample cycle. Count, the flags and data_o reflect it from that edge.
- data_read_i with empty=0 pops on that edge; data_o shows the next byte (or holds its last value if the buffer becomes empty).
- data_read_i with empty=1 is ignored.
- A push and a pop in the same cycle leave count unchanged; both pointers advance.
- A pop while full plus a push in the same cycle succeeds: no overflow, full stays 1.
- Pointers wrap modulo BUFFER_DEPTH. The count is log2(BUFFER_DEPTH)+1 bits wide.

Flags:
- All flags are registered from the next count.
- A threshold above BUFFER_DEPTH means avail asserts only when full.

Test Plan:
- Reset, line idle -> empty=1, full=0, avail=0, data_o=0, no error pulses.
- Select 00 (DIV=12, 192 clocks per bit); send 0xA5 with a good stop bit -> empty falls within 1 clock after mid-stop; data_o=0xA5; pulse read -> empty=1.
- Select 11 (DIV=1); send 0x3C with the stop bit held low -> frame_error_o high for exactly 1 cycle; empty stays 1.
- Low glitch of 5 bit-ticks on the idle line -> FSM returns to IDLE; no byte stored, no error.
- Threshold=4; send 0x01..0x04 -> avail rises on the 4th write. Then send 28 more -> full=1. Send 0xFF -> overflow_o pulses and data_o still reads 0x01.
- With full=1, read on the same cycle as the next write commits -> no overflow, full stays 1. Then switch baud mid-frame -> the current byte still decodes correctly at the old rate; assert reset mid-frame -> all outputs return to reset values.
